cordic_phase_seq: RTL and testbench

//   Upstream driver for cordic_sin_cos. Generates a phase-accumulator angle sequence,

---
 rtl/cordic_phase_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_cordic_phase_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_seq.sv
// Phase-accumulator angle sequencer that drives a CORDIC sin/cos core and
// registers each completed cos/sin sample. It supports bursts of a fixed length
// or continuous operation until stop. It aborts with a sticky error if the
// CORDIC stalls.
module cordic_phase_seq #(
    parameter int unsigned ANG_W   = 11,
    parameter int unsigned ANG_MOD = 1024,
    parameter int unsigned OUT_W   = 13,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TMO_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_vld,
    input  logic             soft_rst,
    input  logic             start,
    input  logic             stop,
    input  logic [ANG_W-1:0] phase_init,
    input  logic [ANG_W-1:0] phase_step,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic             cordic_trig,
    output logic [ANG_W-1:0] cordic_a,
    input  logic             cordic_vld,
    input  logic [OUT_W-1:0] cordic_cos,
    input  logic [OUT_W-1:0] cordic_sin,
    output logic             smp_vld,
    output logic [OUT_W-1:0] smp_cos,
    output logic [OUT_W-1:0] smp_sin,
    output logic [CNT_W-1:0] smp_idx
);

    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [ANG_W:0]   MOD_V   = (ANG_W + 1)'(ANG_MOD);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_HI,
        S_WAIT_LO
    } state_e;

    state_e           state_q, state_d;
    logic [ANG_W-1:0] acc_q, acc_d;
    logic [ANG_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             stop_pend_q, stop_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_err_q, tmo_err_d;
    logic             trig_q, trig_d;
    logic [ANG_W-1:0] a_q, a_d;
    logic             smp_vld_q, smp_vld_d;
    logic [OUT_W-1:0] cos_q, cos_d;
    logic [OUT_W-1:0] sin_q, sin_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    logic [ANG_W:0]   acc_sum;
    logic [ANG_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_smp;

    // Next angle reduced modulo one full turn, and end-of-burst detection.
    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, step_q};
        acc_next = ANG_W'((acc_sum >= MOD_V) ? (acc_sum - MOD_V) : acc_sum);
        cnt_inc  = cnt_q + CNT_W'(1);
        last_smp = (len_q != '0) && (cnt_inc == len_q);
    end

    // Next-state logic and registered-output values.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = step_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        stop_pend_d = stop_pend_q | ((state_q != S_IDLE) & stop);
        done_d      = 1'b0;
        tmo_err_d   = tmo_err_q;
        trig_d      = 1'b0;
        a_d         = a_q;
        smp_vld_d   = 1'b0;
        cos_d       = cos_q;
        sin_d       = sin_q;
        idx_d       = idx_q;

        unique case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    acc_d     = phase_init;
                    step_d    = phase_step;
                    len_d     = burst_len;
                    cnt_d     = '0;
                    tmo_err_d = 1'b0;
                    trig_d    = 1'b1;
                    a_d       = phase_init;
                    state_d   = S_TRIG;
                end
            end
            S_TRIG: begin
                tmo_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (cordic_vld) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TMO_MAX) begin
                    tmo_err_d   = 1'b1;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!cordic_vld) begin
                    cos_d     = cordic_cos;
                    sin_d     = cordic_sin;
                    idx_d     = cnt_q;
                    smp_vld_d = 1'b1;
                    acc_d     = acc_next;
                    cnt_d     = cnt_inc;
                    // A stop arriving on the completion cycle itself still ends the burst.
                    if (last_smp || stop_pend_q || stop) begin
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        trig_d  = 1'b1;
                        a_d     = acc_next;
                        state_d = S_TRIG;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    tmo_err_d   = 1'b1;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; soft_rst acts on every edge, all else gated by clk_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            step_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
            trig_q      <= 1'b0;
            a_q         <= '0;
            smp_vld_q   <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
            idx_q       <= '0;
        end else if (soft_rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            step_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
            trig_q      <= 1'b0;
            a_q         <= '0;
            smp_vld_q   <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
            idx_q       <= '0;
        end else if (clk_vld) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tmo_err_q   <= tmo_err_d;
            trig_q      <= trig_d;
            a_q         <= a_d;
            smp_vld_q   <= smp_vld_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            idx_q       <= idx_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tmo_err_q;
    assign cordic_trig = trig_q;
    assign cordic_a    = a_q;
    assign smp_vld     = smp_vld_q;
    assign smp_cos     = cos_q;
    assign smp_sin     = sin_q;
    assign smp_idx     = idx_q;

endmodule

// File: tb/tb_cordic_phase_seq.sv
// Bench for cordic_phase_seq: behavioural CORDIC responder, scoreboard of expected
// samples, table of burst vectors, plus hand sequences for timeout and soft reset.
`timescale 1ns/1ps
module tb_cordic_phase_seq;

    localparam int ANG_W = 11;
    localparam int OUT_W = 13;
    localparam int CNT_W = 16;
    localparam real PI = 3.14159265358979;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clk_vld = 1'b1;
    logic                    soft_rst = 1'b0;
    logic                    start = 1'b0;
    logic                    stop = 1'b0;
    logic [ANG_W-1:0]        phase_init = '0;
    logic [ANG_W-1:0]        phase_step = '0;
    logic [CNT_W-1:0]        burst_len = '0;
    logic                    busy, done, timeout_err, cordic_trig;
    logic [ANG_W-1:0]        cordic_a;
    logic                    cordic_vld = 1'b0;
    logic signed [OUT_W-1:0] cordic_cos = '0;
    logic signed [OUT_W-1:0] cordic_sin = '0;
    logic                    smp_vld;
    logic signed [OUT_W-1:0] smp_cos, smp_sin;
    logic [CNT_W-1:0]        smp_idx;

    cordic_phase_seq #(
        .ANG_W(ANG_W), .ANG_MOD(1024), .OUT_W(OUT_W), .CNT_W(CNT_W), .TMO_CYC(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_vld(clk_vld), .soft_rst(soft_rst),
        .start(start), .stop(stop), .phase_init(phase_init), .phase_step(phase_step),
        .burst_len(burst_len), .busy(busy), .done(done), .timeout_err(timeout_err),
        .cordic_trig(cordic_trig), .cordic_a(cordic_a), .cordic_vld(cordic_vld),
        .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .smp_vld(smp_vld),
        .smp_cos(smp_cos), .smp_sin(smp_sin), .smp_idx(smp_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int c;
        int s;
    } exp_t;

    typedef struct {
        int init;
        int step;
        int len;
        int lat;
        int stop_at;
        bit start_mid;
        bit stop_idle;
        bit tog;
        int exp_n;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    int   lat = 1;
    bit   hang = 1'b0;
    bit   tog = 1'b0;
    int   trig_cnt = 0, smp_cnt = 0, done_cnt = 0, ecount = 0;
    int   trig_edge = 0, done_edge = 0;
    bit   en_edge = 1'b0;
    int   e_init = 0, e_step = 0, k_exp = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
        checks++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d+-%0d", nm, act, exp, tol);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Clock-enable pattern: steady 1, or alternating when tog is set.
    initial begin : en_gen
        forever begin
            @(negedge clk);
            clk_vld = tog ? ~clk_vld : 1'b1;
        end
    end

    // CORDIC responder: vld rises after an accepted trig, falls lat enabled edges later.
    initial begin : cordic_model
        logic             trg_s;
        logic [ANG_W-1:0] a_s;
        bit               act, sr;
        int               mcnt, ea, nz;
        real              x;
        exp_t             e;
        mcnt = 0;
        forever begin
            @(negedge clk);
            trg_s = cordic_trig;
            a_s   = cordic_a;
            @(posedge clk);
            en_edge = clk_vld || soft_rst;
            act     = rst_n && clk_vld;
            sr      = soft_rst;
            #1;
            if (act && !sr) begin
                ecount++;
                if (trg_s) begin
                    trig_cnt++;
                    trig_edge = ecount;
                    ea = (e_init + k_exp * e_step) % 1024;
                    chk("cordic_a", int'(a_s), ea);
                    if (!hang) begin
                        e.idx = k_exp % 65536;
                        e.c   = int'(2048.0 * $cos(real'(ea) * PI / 512.0));
                        e.s   = int'(2048.0 * $sin(real'(ea) * PI / 512.0));
                        sbq.push_back(e);
                        x  = real'(a_s) * PI / 512.0;
                        nz = int'($urandom_range(2, 0)) - 1;
                        cordic_cos = OUT_W'(int'(2048.0 * $cos(x)) + nz);
                        cordic_sin = OUT_W'(int'(2048.0 * $sin(x)) - nz);
                        cordic_vld = 1'b1;
                        mcnt = lat;
                    end
                    k_exp++;
                end else if (cordic_vld) begin
                    mcnt--;
                    if (mcnt <= 0) cordic_vld = 1'b0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each smp_vld, counts done pulses.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (en_edge && rst_n) begin
                if (smp_vld) begin
                    smp_cnt++;
                    if (sbq.size() == 0) begin
                        chk("sb_nonempty", sbq.size(), 1);
                    end else begin
                        e = sbq.pop_front();
                        chk("smp_idx", int'(smp_idx), e.idx);
                        chk_tol("smp_cos", int'(smp_cos), e.c, 3);
                        chk_tol("smp_sin", int'(smp_sin), e.s, 3);
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_edge = ecount;
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=expired required=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start_until_busy(input string nm);
        int n;
        n = 0;
        start = 1'b1;
        do begin
            tick();
            n++;
        end while (!busy && n < 10);
        start = 1'b0;
        if (!busy) chk({nm, "_start_accept"}, int'(busy), 1);
    endtask

    task automatic wait_trigs(input int t0, input int nt, input string nm);
        int n;
        n = 0;
        while ((trig_cnt - t0) < nt && n < 5000) begin
            tick();
            n++;
        end
        if ((trig_cnt - t0) < nt) chk({nm, "_trig_wait"}, trig_cnt - t0, nt);
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            tick();
            n++;
        end
        if (done_cnt == d0) chk({nm, "_done_wait"}, done_cnt - d0, 1);
    endtask

    task automatic run_burst(input vec_t v, input string nm);
        int s0, d0, t0;
        sbq.delete();
        k_exp  = 0;
        e_init = v.init;
        e_step = v.step;
        lat    = v.lat;
        hang   = 1'b0;
        if (v.stop_idle) begin
            d0   = done_cnt;
            stop = 1'b1;
            tick();
            stop = 1'b0;
            repeat (3) tick();
            chk({nm, "_idle_stop_done"}, done_cnt - d0, 0);
            chk({nm, "_idle_stop_busy"}, int'(busy), 0);
        end
        tog = v.tog;
        s0 = smp_cnt;
        d0 = done_cnt;
        t0 = trig_cnt;
        phase_init = ANG_W'(v.init);
        phase_step = ANG_W'(v.step);
        burst_len  = CNT_W'(v.len);
        pulse_start_until_busy(nm);
        chk({nm, "_tmo_err_clr"}, int'(timeout_err), 0);
        if (v.start_mid) begin
            wait_trigs(t0, 1, nm);
            phase_init = 11'd999;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (v.stop_at > 0) begin
            wait_trigs(t0, v.stop_at, nm);
            tick();
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        wait_done(d0, nm);
        repeat (4) tick();
        tog = 1'b0;
        repeat (2) tick();
        chk({nm, "_smp_cnt"}, smp_cnt - s0, v.exp_n);
        chk({nm, "_trig_cnt"}, trig_cnt - t0, v.exp_n);
        chk({nm, "_done_cnt"}, done_cnt - d0, 1);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_tmo_err"}, int'(timeout_err), 0);
        chk({nm, "_sb_left"}, sbq.size(), 0);
    endtask

    initial begin : main
        vec_t vt[8];
        vec_t fv;
        int   s0, d0, t0;

        //        init  step len   lat stop mid idl tog  exp
        vt[0] = '{0,    1,   1024, 1,  0,   0,  0,  0,   1024};
        vt[1] = '{1020, 7,   3,    3,  0,   0,  0,  0,   3};
        vt[2] = '{100,  13,  0,    4,  5,   0,  0,  0,   5};
        vt[3] = '{1023, 1023, 1,   2,  0,   0,  0,  0,   1};
        vt[4] = '{1023, 1,   2,    1,  0,   0,  0,  0,   2};
        vt[5] = '{200,  300, 3,    2,  0,   1,  0,  0,   3};
        vt[6] = '{0,    512, 2,    1,  0,   0,  1,  0,   2};
        vt[7] = '{50,   77,  4,    2,  0,   0,  0,  1,   4};

        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tmo_err", int'(timeout_err), 0);
        chk("rst_trig", int'(cordic_trig), 0);
        chk("rst_a", int'(cordic_a), 0);
        chk("rst_smp_vld", int'(smp_vld), 0);
        chk("rst_cos", int'(smp_cos), 0);
        chk("rst_sin", int'(smp_sin), 0);
        chk("rst_idx", int'(smp_idx), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) run_burst(vt[i], $sformatf("v%0d", i));

        // Stalled CORDIC: abort 64 enabled cycles after WAIT_HI entry.
        sbq.delete();
        k_exp  = 0;
        e_init = 300;
        e_step = 1;
        lat    = 1;
        hang   = 1'b1;
        s0 = smp_cnt;
        d0 = done_cnt;
        t0 = trig_cnt;
        phase_init = 11'd300;
        phase_step = 11'd1;
        burst_len  = 16'd4;
        pulse_start_until_busy("tmo");
        wait_done(d0, "tmo");
        repeat (2) tick();
        chk("tmo_latency", done_edge - trig_edge, 64);
        chk("tmo_err_set", int'(timeout_err), 1);
        chk("tmo_no_smp", smp_cnt - s0, 0);
        chk("tmo_done_cnt", done_cnt - d0, 1);
        chk("tmo_trig_cnt", trig_cnt - t0, 1);
        chk("tmo_busy", int'(busy), 0);
        hang = 1'b0;
        fv = '{5, 9, 1, 1, 0, 0, 0, 0, 1};
        run_burst(fv, "after_tmo");

        // Soft reset while waiting for the CORDIC, with the clock enable toggling.
        sbq.delete();
        k_exp  = 0;
        e_init = 10;
        e_step = 3;
        lat    = 6;
        tog    = 1'b1;
        t0 = trig_cnt;
        phase_init = 11'd10;
        phase_step = 11'd3;
        burst_len  = 16'd0;
        pulse_start_until_busy("sr");
        wait_trigs(t0, 2, "sr");
        repeat (4) tick();
        chk("sr_pre_busy", int'(busy), 1);
        chk("sr_pre_smp", smp_cnt > 0 ? 1 : 0, 1);
        s0 = smp_cnt;
        d0 = done_cnt;
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("sr_busy", int'(busy), 0);
        chk("sr_done", int'(done), 0);
        chk("sr_trig", int'(cordic_trig), 0);
        chk("sr_a", int'(cordic_a), 0);
        chk("sr_smp_vld", int'(smp_vld), 0);
        chk("sr_cos", int'(smp_cos), 0);
        chk("sr_sin", int'(smp_sin), 0);
        chk("sr_idx", int'(smp_idx), 0);
        chk("sr_tmo_err", int'(timeout_err), 0);
        tog = 1'b0;
        repeat (20) tick();
        chk("sr_after_done", done_cnt - d0, 0);
        chk("sr_after_smp", smp_cnt - s0, 0);
        chk("sr_after_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
